// File: rtl/sprite_pkg.sv
// Sprite kinds, per-kind RAM layout, and the background / blank addresses
// shared by the sprite fetch pipeline.
package sprite_pkg;

  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    CANNONBALL = 3'd1,
    DEMO_R_RED = 3'd2,
    DEMO_L_RED = 3'd3,
    DEMO_R_BLU = 3'd4,
    DEMO_L_BLU = 3'd5
  } sprite_kind_t;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 11;

  localparam logic [ADDR_W-1:0] ADDR_SKY    = 11'd1704;
  localparam logic [ADDR_W-1:0] ADDR_GROUND = 11'd1705;
  localparam logic [ADDR_W-1:0] ADDR_BLANK  = 11'd1706;

  localparam logic [7:0] SKY_IDX     = 8'h1F;
  localparam logic [7:0] GROUND_IDX  = 8'h2E;
  localparam logic [7:0] TRANSPARENT = 8'h00;

  // Unused codes (6, 7) report zero size so they can never hit.
  function automatic logic [ADDR_W-1:0] kind_base(input sprite_kind_t k);
    case (k)
      CANNONBALL: return 11'd0;
      DEMO_R_RED: return 11'd204;
      DEMO_L_RED: return 11'd579;
      DEMO_R_BLU: return 11'd954;
      DEMO_L_BLU: return 11'd1329;
      default:    return 11'd0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] kind_w(input sprite_kind_t k);
    case (k)
      CANNONBALL:                                     return 11'd12;
      DEMO_R_RED, DEMO_L_RED, DEMO_R_BLU, DEMO_L_BLU: return 11'd15;
      default:                                        return 11'd0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] kind_h(input sprite_kind_t k);
    case (k)
      CANNONBALL:                                     return 11'd17;
      DEMO_R_RED, DEMO_L_RED, DEMO_R_BLU, DEMO_L_BLU: return 11'd25;
      default:                                        return 11'd0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Single object slot: bounding-box test of the current pixel and the
// row-major offset of that pixel inside the sprite bitmap.
module sprite_hit
  import sprite_pkg::*;
(
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               en,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [2:0]         kind,
  output logic               hit,
  output logic [ADDR_W-1:0]  offset
);

  sprite_kind_t      k;
  logic [ADDR_W-1:0] px, py, ox, oy, w, h, dx, dy;

  // Everything is widened to 11 bits so an object near x=1023 does not
  // wrap around and claim pixels at the left edge.
  always_comb begin
    k      = sprite_kind_t'(kind);
    px     = {1'b0, draw_x};
    py     = {1'b0, draw_y};
    ox     = {1'b0, obj_x};
    oy     = {1'b0, obj_y};
    w      = kind_w(k);
    h      = kind_h(k);
    dx     = px - ox;
    dy     = py - oy;
    hit    = en && (k != KIND_NONE) &&
             (px >= ox) && (px < ox + w) &&
             (py >= oy) && (py < oy + h);
    offset = dy * w + dx;
  end

endmodule

// File: rtl/sprite_fetch.sv
// Per-pixel sprite fetch: priority-resolves the object slots, issues the
// sprite RAM read, and merges the returned byte with the background.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int N_OBJ    = 3,
  parameter int GROUND_Y = 400
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             draw_x,
  input  logic [COORD_W-1:0]             draw_y,
  input  logic [N_OBJ-1:0]               obj_en,
  input  logic [N_OBJ-1:0][COORD_W-1:0]  obj_x,
  input  logic [N_OBJ-1:0][COORD_W-1:0]  obj_y,
  input  logic [N_OBJ-1:0][2:0]          obj_kind,
  output logic [ADDR_W-1:0]              read_address,
  input  logic [7:0]                     ram_data,
  output logic [7:0]                     pix_idx,
  output logic                           pix_out_valid,
  output logic                           pix_is_sprite
);

  localparam logic [COORD_W-1:0] GROUND_ROW = COORD_W'(GROUND_Y);

  logic [N_OBJ-1:0]              slot_hit;
  logic [N_OBJ-1:0][ADDR_W-1:0]  slot_off;

  logic              win_hit;
  sprite_kind_t      win_kind;
  logic [ADDR_W-1:0] win_off;
  logic              on_ground;
  logic [ADDR_W-1:0] addr_next;

  logic vld_p0, hit_p0, bg_p0;
  logic vld_p1, hit_p1, bg_p1;

  logic [7:0] out_idx;
  logic       out_spr;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_slot
    sprite_hit u_hit (
      .draw_x (draw_x),
      .draw_y (draw_y),
      .en     (obj_en[g]),
      .obj_x  (obj_x[g]),
      .obj_y  (obj_y[g]),
      .kind   (obj_kind[g]),
      .hit    (slot_hit[g]),
      .offset (slot_off[g])
    );
  end

  // Scan from the lowest-priority slot upward so slot 0 overrides last.
  always_comb begin
    win_hit  = 1'b0;
    win_kind = KIND_NONE;
    win_off  = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        win_hit  = 1'b1;
        win_kind = sprite_kind_t'(obj_kind[i]);
        win_off  = slot_off[i];
      end
    end
  end

  always_comb begin
    on_ground = (draw_y >= GROUND_ROW);
    if (!pix_valid)
      addr_next = ADDR_BLANK;
    else if (win_hit)
      addr_next = kind_base(win_kind) + win_off;
    else
      addr_next = on_ground ? ADDR_GROUND : ADDR_SKY;
  end

  // p0: read address issued, pixel attributes captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_address <= ADDR_BLANK;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
    end else begin
      read_address <= addr_next;
      vld_p0       <= pix_valid;
      vld_p1       <= vld_p0;
    end
  end

  // p1: attributes aligned with ram_data
  always_ff @(posedge clk) begin
    hit_p0 <= pix_valid & win_hit;
    bg_p0  <= on_ground;
    hit_p1 <= hit_p0;
    bg_p1  <= bg_p0;
  end

  always_comb begin
    out_idx = 8'h00;
    out_spr = 1'b0;
    if (vld_p1) begin
      if (hit_p1 && ram_data != TRANSPARENT) begin
        out_idx = ram_data;
        out_spr = 1'b1;
      end else if (hit_p1) begin
        out_idx = bg_p1 ? GROUND_IDX : SKY_IDX;
      end else begin
        out_idx = ram_data;
      end
    end
  end

  // p2: resolved palette byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_idx       <= 8'h00;
      pix_out_valid <= 1'b0;
      pix_is_sprite <= 1'b0;
    end else begin
      pix_idx       <= out_idx;
      pix_out_valid <= vld_p1;
      pix_is_sprite <= out_spr;
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a registered sprite RAM model.
module tb_sprite_fetch;
  import sprite_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pix_valid;
  logic [9:0]       draw_x, draw_y;
  logic [2:0]       obj_en;
  logic [2:0][9:0]  obj_x, obj_y;
  logic [2:0][2:0]  obj_kind;
  logic [10:0]      read_address;
  logic [7:0]       ram_data;
  logic [7:0]       pix_idx;
  logic             pix_out_valid;
  logic             pix_is_sprite;

  logic [7:0] mem [0:2047];

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        pv;
    logic [9:0]  x, y;
    logic [2:0]  en;
    logic [8:0]  kinds;
    logic [29:0] oxs, oys;
    logic [10:0] ea;
    logic        ev;
    logic [7:0]  ei;
    logic        es;
  } vec_t;

  vec_t vq[$];

  sprite_fetch #(.N_OBJ(3), .GROUND_Y(400)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_valid     (pix_valid),
    .draw_x        (draw_x),
    .draw_y        (draw_y),
    .obj_en        (obj_en),
    .obj_x         (obj_x),
    .obj_y         (obj_y),
    .obj_kind      (obj_kind),
    .read_address  (read_address),
    .ram_data      (ram_data),
    .pix_idx       (pix_idx),
    .pix_out_valid (pix_out_valid),
    .pix_is_sprite (pix_is_sprite)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[read_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic vec_t mk(input logic pv, input logic [9:0] x, input logic [9:0] y,
                              input logic [2:0] en, input logic [8:0] kinds,
                              input logic [29:0] oxs, input logic [29:0] oys,
                              input logic [10:0] ea, input logic ev, input logic [7:0] ei,
                              input logic es);
    vec_t v;
    v.pv = pv; v.x = x; v.y = y; v.en = en; v.kinds = kinds;
    v.oxs = oxs; v.oys = oys; v.ea = ea; v.ev = ev; v.ei = ei; v.es = es;
    return v;
  endfunction

  task automatic idle_inputs();
    pix_valid = 1'b0; draw_x = '0; draw_y = '0;
    obj_en = '0; obj_x = '0; obj_y = '0; obj_kind = '0;
  endtask

  localparam logic [2:0] KN  = 3'(KIND_NONE);
  localparam logic [2:0] KCB = 3'(CANNONBALL);
  localparam logic [2:0] KRR = 3'(DEMO_R_RED);
  localparam logic [2:0] KLR = 3'(DEMO_L_RED);
  localparam logic [2:0] KRB = 3'(DEMO_R_BLU);
  localparam logic [2:0] KLB = 3'(DEMO_L_BLU);

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h80 | 8'(i[6:0]);
    mem[235]  = 8'h2A;
    mem[1329] = 8'h3C;
    mem[203]  = 8'h55;
    mem[954]  = 8'h00;
    mem[953]  = 8'h00;
    mem[1704] = 8'h11;
    mem[1705] = 8'h22;

    // kinds / coordinates packed as {slot2, slot1, slot0}
    vq.push_back(mk(1, 101, 52,  3'b001, {KN, KN, KRR},  {10'd0, 10'd0, 10'd100},   {10'd0, 10'd0, 10'd50},   11'd235,  1, 8'h2A, 1));
    vq.push_back(mk(1, 200, 200, 3'b011, {KN, KCB, KLB}, {10'd0, 10'd200, 10'd200}, {10'd0, 10'd200, 10'd200}, 11'd1329, 1, 8'h3C, 1));
    vq.push_back(mk(1, 10, 399,  3'b000, {KN, KN, KN},   30'd0, 30'd0, 11'd1704, 1, 8'h11, 0));
    vq.push_back(mk(1, 10, 400,  3'b000, {KN, KN, KN},   30'd0, 30'd0, 11'd1705, 1, 8'h22, 0));
    vq.push_back(mk(0, 10, 10,   3'b000, {KN, KN, KN},   30'd0, 30'd0, 11'd1706, 0, 8'h00, 0));
    vq.push_back(mk(1, 11, 16,   3'b001, {KN, KN, KCB},  30'd0, 30'd0, 11'd203,  1, 8'h55, 1));
    vq.push_back(mk(1, 12, 16,   3'b001, {KN, KN, KCB},  30'd0, 30'd0, 11'd1704, 1, 8'h11, 0));
    vq.push_back(mk(1, 11, 17,   3'b001, {KN, KN, KCB},  30'd0, 30'd0, 11'd1704, 1, 8'h11, 0));
    vq.push_back(mk(1, 3, 5,     3'b001, {KN, KN, KCB},  {10'd0, 10'd0, 10'd1020}, 30'd0, 11'd1704, 1, 8'h11, 0));
    vq.push_back(mk(1, 1023, 5,  3'b001, {KN, KN, KCB},  {10'd0, 10'd0, 10'd1020}, 30'd0, 11'd63,   1, 8'hBF, 1));
    vq.push_back(mk(1, 300, 300, 3'b100, {KRB, KN, KN},  {10'd300, 10'd0, 10'd0}, {10'd300, 10'd0, 10'd0}, 11'd954, 1, 8'h1F, 0));
    vq.push_back(mk(1, 64, 444,  3'b100, {KLR, KN, KN},  {10'd50, 10'd0, 10'd0},  {10'd420, 10'd0, 10'd0}, 11'd953, 1, 8'h2E, 0));
    vq.push_back(mk(0, 101, 52,  3'b001, {KN, KN, KRR},  {10'd0, 10'd0, 10'd100}, {10'd0, 10'd0, 10'd50}, 11'd1706, 0, 8'h00, 0));
    vq.push_back(mk(1, 101, 52,  3'b110, {KRR, KCB, KRR}, {10'd100, 10'd100, 10'd100}, {10'd50, 10'd50, 10'd50}, 11'd25, 1, 8'h99, 1));
    vq.push_back(mk(1, 5, 5,     3'b001, {KN, KN, KN},   30'd0, 30'd0, 11'd1704, 1, 8'h11, 0));

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_read_address", 32'(read_address), 32'd1706);
    check("reset_pix_idx", 32'(pix_idx), 32'h00);
    check("reset_pix_out_valid", 32'(pix_out_valid), 32'd0);
    check("reset_pix_is_sprite", 32'(pix_is_sprite), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      pix_valid = vq[k].pv; draw_x = vq[k].x; draw_y = vq[k].y;
      obj_en = vq[k].en; obj_kind = vq[k].kinds; obj_x = vq[k].oxs; obj_y = vq[k].oys;
      @(posedge clk); #1;
      check($sformatf("v%0d_read_address", k), 32'(read_address), 32'(vq[k].ea));
      idle_inputs();
      @(posedge clk);
      @(posedge clk); #1;
      check($sformatf("v%0d_pix_out_valid", k), 32'(pix_out_valid), 32'(vq[k].ev));
      if (vq[k].ev) check($sformatf("v%0d_pix_idx", k), 32'(pix_idx), 32'(vq[k].ei));
      check($sformatf("v%0d_pix_is_sprite", k), 32'(pix_is_sprite), 32'(vq[k].es));
    end

    // Reset asserted while valid pixels are flowing.
    @(negedge clk);
    pix_valid = 1'b1; draw_x = 10'd10; draw_y = 10'd10;
    repeat (3) @(negedge clk);
    check("pre_reset_valid", 32'(pix_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_read_address", 32'(read_address), 32'd1706);
    check("midreset_pix_out_valid", 32'(pix_out_valid), 32'd0);
    repeat (2) @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_reset_no_stale_%0d", c), 32'(pix_out_valid), 32'd0);
    end
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    check("first_pixel_edge1", 32'(pix_out_valid), 32'd0);
    @(negedge clk);
    check("first_pixel_edge2", 32'(pix_out_valid), 32'd0);
    @(negedge clk);
    check("first_pixel_edge3", 32'(pix_out_valid), 32'd1);
    check("first_pixel_idx", 32'(pix_idx), 32'h11);

    // Back-to-back 640-pixel sky line.
    begin
      int vcount = 0, rises = 0, bad_idx = 0;
      logic prev = 1'b0;
      for (int c = 0; c < 660; c++) begin
        @(negedge clk);
        if (pix_out_valid) begin
          vcount++;
          if (pix_idx !== 8'h11) bad_idx++;
        end
        if (pix_out_valid && !prev) rises++;
        prev = pix_out_valid;
        pix_valid = (c < 640);
        draw_x = 10'(c); draw_y = 10'd10;
      end
      check("line_valid_count", 32'(vcount), 32'd640);
      check("line_contiguous_runs", 32'(rises), 32'd1);
      check("line_bad_idx", 32'(bad_idx), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
